// File: rtl/lc4_alu_arbiter.sv
// ============================================================================
// lc4_alu_arbiter -- two requesters share one combinational LC4 ALU. Rev 1.0
// ============================================================================
`default_nettype none

module lc4_alu (
   input  logic [15:0] i_insn,
   input  logic [15:0] i_pc,
   input  logic [15:0] i_r1data,
   input  logic [15:0] i_r2data,
   output logic [15:0] o_result
);
   logic [15:0] pc_inc, imm5, imm6, imm7, imm9, imm11;

   assign pc_inc = i_pc + 16'd1;
   assign imm5   = {{11{i_insn[4]}},  i_insn[4:0]};
   assign imm6   = {{10{i_insn[5]}},  i_insn[5:0]};
   assign imm7   = {{9{i_insn[6]}},   i_insn[6:0]};
   assign imm9   = {{7{i_insn[8]}},   i_insn[8:0]};
   assign imm11  = {{5{i_insn[10]}},  i_insn[10:0]};

   function automatic logic [15:0] cmp3(input logic lt, input logic eq);
      return lt ? 16'hFFFF : (eq ? 16'h0000 : 16'h0001);
   endfunction

   always_comb begin
      o_result = 16'h0000;
      case (i_insn[15:12])
         4'h0: o_result = pc_inc + imm9;
         4'h1: begin
            if (i_insn[5]) o_result = i_r1data + imm5;
            else begin
               case (i_insn[4:3])
                  2'd0:    o_result = i_r1data + i_r2data;
                  2'd1:    o_result = i_r1data * i_r2data;
                  2'd2:    o_result = i_r1data - i_r2data;
                  default: o_result = (i_r2data == 16'd0) ? 16'd0 : i_r1data / i_r2data;
               endcase
            end
         end
         4'h2: begin
            case (i_insn[8:7])
               2'd0:    o_result = cmp3($signed(i_r1data) < $signed(i_r2data), i_r1data == i_r2data);
               2'd1:    o_result = cmp3(i_r1data < i_r2data, i_r1data == i_r2data);
               2'd2:    o_result = cmp3($signed(i_r1data) < $signed(imm7), i_r1data == imm7);
               default: o_result = cmp3(i_r1data < {9'd0, i_insn[6:0]}, i_r1data == {9'd0, i_insn[6:0]});
            endcase
         end
         4'h4: o_result = i_insn[11] ? {i_pc[15], i_insn[10:0], 4'b0000} : i_r1data;
         4'h5: begin
            if (i_insn[5]) o_result = i_r1data & imm5;
            else begin
               case (i_insn[4:3])
                  2'd0:    o_result = i_r1data & i_r2data;
                  2'd1:    o_result = ~i_r1data;
                  2'd2:    o_result = i_r1data | i_r2data;
                  default: o_result = i_r1data ^ i_r2data;
               endcase
            end
         end
         4'h6, 4'h7: o_result = i_r1data + imm6;
         4'h8: o_result = i_r1data;
         4'h9: o_result = imm9;
         4'hA: begin
            case (i_insn[5:4])
               2'd0:    o_result = i_r1data << i_insn[3:0];
               2'd1:    o_result = 16'($signed(i_r1data) >>> i_insn[3:0]);
               2'd2:    o_result = i_r1data >> i_insn[3:0];
               default: o_result = (i_r2data == 16'd0) ? 16'd0 : i_r1data % i_r2data;
            endcase
         end
         4'hC: o_result = i_insn[11] ? pc_inc + imm11 : i_r1data;
         4'hD: o_result = {i_insn[7:0], i_r1data[7:0]};
         4'hF: o_result = {8'h80, i_insn[7:0]};
         default: o_result = 16'h0000;
      endcase
   end
endmodule

module lc4_alu_arbiter #(
   parameter int FIXED_PRIORITY = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req0_valid,
   output logic        o_req0_ready,
   input  logic [15:0] i_req0_insn,
   input  logic [15:0] i_req0_pc,
   input  logic [15:0] i_req0_r1data,
   input  logic [15:0] i_req0_r2data,
   output logic        o_rsp0_valid,
   input  logic        i_rsp0_ready,
   output logic [15:0] o_rsp0_result,
   input  logic        i_req1_valid,
   output logic        o_req1_ready,
   input  logic [15:0] i_req1_insn,
   input  logic [15:0] i_req1_pc,
   input  logic [15:0] i_req1_r1data,
   input  logic [15:0] i_req1_r2data,
   output logic        o_rsp1_valid,
   input  logic        i_rsp1_ready,
   output logic [15:0] o_rsp1_result,
   output logic [15:0] o_acc_cnt0,
   output logic [15:0] o_acc_cnt1,
   output logic        o_busy
);
   logic        op_valid, op_tag, last_grant, prio0, prio1;
   logic [15:0] op_insn, op_pc, op_r1, op_r2, alu_result;
   logic [15:0] acc_cnt0, acc_cnt1;
   logic [15:0] rsp_data [2];
   logic [1:0]  req_valid, rsp_valid, pop, eligible, ready, accept;

   assign req_valid = {i_req1_valid, i_req0_valid};
   assign pop       = rsp_valid & {i_rsp1_ready, i_rsp0_ready};

   // Round-robin hands priority to whichever requester did not win last.
   assign prio1 = (FIXED_PRIORITY == 0) && !last_grant;
   assign prio0 = !prio1;

   // Ready is held low during reset even though the state already reads idle.
   assign ready[0] = rst_n && eligible[0] && !(req_valid[1] && eligible[1] && prio1);
   assign ready[1] = rst_n && eligible[1] && !(req_valid[0] && eligible[0] && prio0);
   assign accept   = req_valid & ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_valid   <= 1'b0;
         op_tag     <= 1'b0;
         op_insn    <= 16'h0000;
         op_pc      <= 16'h0000;
         op_r1      <= 16'h0000;
         op_r2      <= 16'h0000;
         last_grant <= 1'b1;
         acc_cnt0   <= 16'h0000;
         acc_cnt1   <= 16'h0000;
      end else begin
         op_valid <= |accept;
         if (|accept) begin
            op_tag     <= accept[1];
            last_grant <= accept[1];
            op_insn    <= accept[1] ? i_req1_insn   : i_req0_insn;
            op_pc      <= accept[1] ? i_req1_pc     : i_req0_pc;
            op_r1      <= accept[1] ? i_req1_r1data : i_req0_r1data;
            op_r2      <= accept[1] ? i_req1_r2data : i_req0_r2data;
         end
         if (accept[0]) acc_cnt0 <= acc_cnt0 + 16'd1;
         if (accept[1]) acc_cnt1 <= acc_cnt1 + 16'd1;
      end
   end

   lc4_alu u_alu (
      .i_insn   (op_insn),
      .i_pc     (op_pc),
      .i_r1data (op_r1),
      .i_r2data (op_r2),
      .o_result (alu_result)
   );

   generate
      for (genvar k = 0; k < 2; k++) begin : g_rsp
         logic        buf_valid;
         logic [15:0] buf_data;
         logic        wr;

         assign wr          = op_valid && (op_tag == 1'(k));
         assign eligible[k] = (!buf_valid || pop[k]) && !wr;
         assign rsp_valid[k] = buf_valid;
         assign rsp_data[k]  = buf_data;

         // A write landing on the pop cycle keeps the buffer full.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               buf_valid <= 1'b0;
               buf_data  <= 16'h0000;
            end else if (wr) begin
               buf_valid <= 1'b1;
               buf_data  <= alu_result;
            end else if (pop[k]) begin
               buf_valid <= 1'b0;
            end
         end
      end
   endgenerate

   assign o_req0_ready  = ready[0];
   assign o_req1_ready  = ready[1];
   assign o_rsp0_valid  = rsp_valid[0];
   assign o_rsp1_valid  = rsp_valid[1];
   assign o_rsp0_result = rsp_data[0];
   assign o_rsp1_result = rsp_data[1];
   assign o_acc_cnt0    = acc_cnt0;
   assign o_acc_cnt1    = acc_cnt1;
   assign o_busy        = op_valid | rsp_valid[0] | rsp_valid[1];
endmodule

`default_nettype wire

// File: tb/tb_lc4_alu_arbiter.sv
// ============================================================================
// tb_lc4_alu_arbiter -- random + directed bench, round-robin and fixed. Rev 1.0
// ============================================================================
`default_nettype none

module tb_lc4_alu_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  v, rr;
   logic [15:0] insn [2];
   logic [15:0] pc [2];
   logic [15:0] a [2];
   logic [15:0] b [2];

   logic        rr_rdy0, rr_rdy1, rr_vld0, rr_vld1, rr_busy;
   logic [15:0] rr_res0, rr_res1, rr_cnt0, rr_cnt1;
   logic        fp_rdy0, fp_rdy1, fp_vld0, fp_vld1, fp_busy;
   logic [15:0] fp_res0, fp_res1, fp_cnt0, fp_cnt1;

   lc4_alu_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .i_req0_valid(v[0]), .o_req0_ready(rr_rdy0), .i_req0_insn(insn[0]),
      .i_req0_pc(pc[0]), .i_req0_r1data(a[0]), .i_req0_r2data(b[0]),
      .o_rsp0_valid(rr_vld0), .i_rsp0_ready(rr[0]), .o_rsp0_result(rr_res0),
      .i_req1_valid(v[1]), .o_req1_ready(rr_rdy1), .i_req1_insn(insn[1]),
      .i_req1_pc(pc[1]), .i_req1_r1data(a[1]), .i_req1_r2data(b[1]),
      .o_rsp1_valid(rr_vld1), .i_rsp1_ready(rr[1]), .o_rsp1_result(rr_res1),
      .o_acc_cnt0(rr_cnt0), .o_acc_cnt1(rr_cnt1), .o_busy(rr_busy));

   lc4_alu_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .i_req0_valid(v[0]), .o_req0_ready(fp_rdy0), .i_req0_insn(insn[0]),
      .i_req0_pc(pc[0]), .i_req0_r1data(a[0]), .i_req0_r2data(b[0]),
      .o_rsp0_valid(fp_vld0), .i_rsp0_ready(rr[0]), .o_rsp0_result(fp_res0),
      .i_req1_valid(v[1]), .o_req1_ready(fp_rdy1), .i_req1_insn(insn[1]),
      .i_req1_pc(pc[1]), .i_req1_r1data(a[1]), .i_req1_r2data(b[1]),
      .o_rsp1_valid(fp_vld1), .i_rsp1_ready(rr[1]), .o_rsp1_result(fp_res1),
      .o_acc_cnt0(fp_cnt0), .o_acc_cnt1(fp_cnt1), .o_busy(fp_busy));

   logic [1:0]  o_rdy [2];
   logic [1:0]  o_vld [2];
   logic [15:0] o_res [2][2];
   logic [15:0] o_cnt [2][2];
   logic        o_bsy [2];
   assign o_rdy[0] = {rr_rdy1, rr_rdy0};
   assign o_rdy[1] = {fp_rdy1, fp_rdy0};
   assign o_vld[0] = {rr_vld1, rr_vld0};
   assign o_vld[1] = {fp_vld1, fp_vld0};
   assign o_res[0][0] = rr_res0;  assign o_res[0][1] = rr_res1;
   assign o_res[1][0] = fp_res0;  assign o_res[1][1] = fp_res1;
   assign o_cnt[0][0] = rr_cnt0;  assign o_cnt[0][1] = rr_cnt1;
   assign o_cnt[1][0] = fp_cnt0;  assign o_cnt[1][1] = fp_cnt1;
   assign o_bsy[0] = rr_busy;
   assign o_bsy[1] = fp_busy;

   int total = 0;
   int bad   = 0;
   string nm [2] = '{"rr", "fp"};

   // Reference model state, one copy per DUT (index 0 round-robin, 1 fixed).
   logic        m_pend [2];
   logic        m_ptag [2];
   logic [15:0] m_pres [2];
   logic [1:0]  m_bv [2];
   logic [15:0] m_bd [2][2];
   logic [15:0] m_cnt [2][2];
   logic        m_last [2];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int sx(input logic [15:0] val, input int n);
      int x;
      x = int'(val) & ((1 << n) - 1);
      if (x >= (1 << (n - 1))) x = x - (1 << n);
      return x;
   endfunction

   function automatic int cmp(input int x, input int y);
      return (x < y) ? -1 : ((x == y) ? 0 : 1);
   endfunction

   function automatic logic [15:0] ref_alu(input logic [15:0] ins, input logic [15:0] p,
                                           input logic [15:0] ra, input logic [15:0] rb);
      int ua, ub, sa, sb, r, sh;
      ua = int'(ra);  ub = int'(rb);
      sa = sx(ra, 16); sb = sx(rb, 16);
      sh = int'(ins[3:0]);
      r  = 0;
      case (int'(ins[15:12]))
         0:  r = int'(p) + 1 + sx(ins, 9);
         1:  if (ins[5]) r = ua + sx(ins, 5);
             else case (int'(ins[4:3]))
                0: r = ua + ub;
                1: r = ua * ub;
                2: r = ua - ub;
                default: r = (ub == 0) ? 0 : ua / ub;
             endcase
         2:  case (int'(ins[8:7]))
                0: r = cmp(sa, sb);
                1: r = cmp(ua, ub);
                2: r = cmp(sa, sx(ins, 7));
                default: r = cmp(ua, int'(ins[6:0]));
             endcase
         4:  r = ins[11] ? ((int'(p) & 'h8000) | ((int'(ins) & 'h7FF) << 4)) : ua;
         5:  if (ins[5]) r = ua & sx(ins, 5);
             else case (int'(ins[4:3]))
                0: r = ua & ub;
                1: r = ~ua;
                2: r = ua | ub;
                default: r = ua ^ ub;
             endcase
         6, 7: r = ua + sx(ins, 6);
         8:  r = ua;
         9:  r = sx(ins, 9);
         10: case (int'(ins[5:4]))
                0: r = ua << sh;
                1: r = sa >>> sh;
                2: r = ua >> sh;
                default: r = (ub == 0) ? 0 : ua % ub;
             endcase
         12: r = ins[11] ? int'(p) + 1 + sx(ins, 11) : ua;
         13: r = (ua & 'hFF) | ((int'(ins) & 'hFF) << 8);
         15: r = 'h8000 | (int'(ins) & 'hFF);
         default: r = 0;
      endcase
      return r[15:0];
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_pend[d] = 1'b0; m_ptag[d] = 1'b0; m_pres[d] = 16'h0;
         m_bv[d] = 2'b00;  m_last[d] = 1'b1;
         for (int k = 0; k < 2; k++) begin
            m_bd[d][k] = 16'h0; m_cnt[d][k] = 16'h0;
         end
      end
   endtask

   task automatic check_reset(input string when);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s %s ready", when, nm[d]), {14'd0, o_rdy[d]}, 16'd0);
         check($sformatf("%s %s rsp_valid", when, nm[d]), {14'd0, o_vld[d]}, 16'd0);
         check($sformatf("%s %s busy", when, nm[d]), {15'd0, o_bsy[d]}, 16'd0);
         for (int k = 0; k < 2; k++) begin
            check($sformatf("%s %s result%0d", when, nm[d], k), o_res[d][k], 16'h0000);
            check($sformatf("%s %s cnt%0d", when, nm[d], k), o_cnt[d][k], 16'h0000);
         end
      end
   endtask

   // One clock: inputs already driven just after a falling edge.
   task automatic step();
      logic [1:0] elig, er, acc;
      logic       p1;
      acc = 2'b00;
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 2; k++)
            elig[k] = (!m_bv[d][k] || rr[k]) && !(m_pend[d] && (m_ptag[d] == k[0]));
         p1 = (d == 0) && !m_last[d];
         er[0] = elig[0] && !(v[1] && elig[1] && p1);
         er[1] = elig[1] && !(v[0] && elig[0] && !p1);
         check($sformatf("%s ready", nm[d]), {14'd0, o_rdy[d]}, {14'd0, er});
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 2; k++)
            elig[k] = (!m_bv[d][k] || rr[k]) && !(m_pend[d] && (m_ptag[d] == k[0]));
         p1 = (d == 0) && !m_last[d];
         acc[0] = v[0] && elig[0] && !(v[1] && elig[1] && p1);
         acc[1] = v[1] && elig[1] && !(v[0] && elig[0] && !p1);
         for (int k = 0; k < 2; k++) begin
            if (m_pend[d] && m_ptag[d] == k[0]) begin
               m_bv[d][k] = 1'b1; m_bd[d][k] = m_pres[d];
            end else if (m_bv[d][k] && rr[k]) begin
               m_bv[d][k] = 1'b0;
            end
         end
         m_pend[d] = |acc;
         for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
               m_ptag[d] = k[0];
               m_last[d] = k[0];
               m_pres[d] = ref_alu(insn[k], pc[k], a[k], b[k]);
               m_cnt[d][k] = m_cnt[d][k] + 16'd1;
            end
         end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s rsp_valid", nm[d]), {14'd0, o_vld[d]}, {14'd0, m_bv[d]});
         check($sformatf("%s busy", nm[d]), {15'd0, o_bsy[d]},
               {15'd0, m_pend[d] | m_bv[d][0] | m_bv[d][1]});
         for (int k = 0; k < 2; k++) begin
            if (m_bv[d][k]) check($sformatf("%s result%0d", nm[d], k), o_res[d][k], m_bd[d][k]);
            check($sformatf("%s cnt%0d", nm[d], k), o_cnt[d][k], m_cnt[d][k]);
         end
      end
   endtask

   task automatic drive(input int k, input logic [15:0] ins, input logic [15:0] p,
                        input logic [15:0] ra, input logic [15:0] rb);
      insn[k] = ins; pc[k] = p; a[k] = ra; b[k] = rb;
   endtask

   initial begin
      rst_n = 1'b0; v = 2'b00; rr = 2'b11;
      for (int k = 0; k < 2; k++) drive(k, 16'h0, 16'h0, 16'h0, 16'h0);
      model_reset();
      repeat (2) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;

      // Single ADD on requester 0.
      drive(0, 16'h1042, 16'h0000, 16'd5, 16'd7);
      v = 2'b01;
      step();
      v = 2'b00;
      check("add rsp0_valid edge0", {15'd0, rr_vld0}, 16'd0);
      step();
      check("add rsp0_valid edge1", {15'd0, rr_vld0}, 16'd1);
      check("add result", rr_res0, 16'h000C);
      check("add cnt0", rr_cnt0, 16'd1);
      step();

      // Tie and alternation: CONST vs TRAP, consumers always ready.
      drive(0, 16'h91FF, 16'h0100, 16'h1111, 16'h2222);
      drive(1, 16'hF025, 16'h0200, 16'h3333, 16'h4444);
      v = 2'b11; rr = 2'b11;
      for (int i = 0; i < 12; i++) begin
         step();
         if (rr_vld0) check("tie rsp0", rr_res0, 16'hFFFF);
         if (rr_vld1) check("tie rsp1", rr_res1, 16'h8025);
      end
      check("tie aggregate rr", rr_cnt0 + rr_cnt1 - 16'd1, 16'd12);

      // Backpressure on requester 0's consumer.
      drive(0, 16'h1008, 16'h0, 16'd100, 16'd23);
      drive(1, 16'h5A1F, 16'h0, 16'h00F0, 16'h0);
      for (int i = 0; i < 3; i++) step();
      rr = 2'b10;
      for (int i = 0; i < 5; i++) step();
      rr = 2'b11;
      for (int i = 0; i < 4; i++) step();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         v = 2'($urandom);
         for (int k = 0; k < 2; k++) begin
            drive(k, 16'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom));
            rr[k] = ($urandom_range(0, 3) != 0);
         end
         step();
      end

      // Reset while an op is in flight.
      v = 2'b00; rr = 2'b11;
      repeat (3) step();
      drive(0, 16'h1042, 16'h0, 16'd9, 16'd1);
      v = 2'b01;
      step();
      v = 2'b00;
      #2 rst_n = 1'b0;
      #1 check_reset("midreset");
      model_reset();
      repeat (2) begin
         @(posedge clk);
         #1 check("midreset rsp0 stays low", {15'd0, rr_vld0}, 16'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      v = 2'b11;
      drive(0, 16'h9005, 16'h0, 16'h0, 16'h0);
      drive(1, 16'hD1AB, 16'h0, 16'h00CD, 16'h0);
      for (int i = 0; i < 4; i++) step();

      // Counter wrap: preload requester 1's counter just below the wrap point.
      v = 2'b00;
      repeat (3) step();
      force dut_rr.acc_cnt1 = 16'hFFFD;
      force dut_fp.acc_cnt1 = 16'hFFFD;
      @(posedge clk);
      #1;
      release dut_rr.acc_cnt1;
      release dut_fp.acc_cnt1;
      m_cnt[0][1] = 16'hFFFD;
      m_cnt[1][1] = 16'hFFFD;
      @(negedge clk);
      v = 2'b10;
      drive(1, 16'h8000, 16'h0, 16'h7777, 16'h0);
      repeat (6) step();
      check("wrap rr cnt1", rr_cnt1, 16'h0000);
      check("wrap fp cnt1", fp_cnt1, 16'h0000);
      v = 2'b00;
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/lc4_alu_arbiter.md
# lc4_alu_arbiter

Shares one combinational `lc4_alu` instance between two requesters (e.g. a main execute path and a secondary/debug path) using valid/ready handshakes. It arbitrates round-robin or fixed-priority, registers the granted operands, evaluates them through the ALU, and returns each result through a one-entry per-requester response buffer. It also keeps per-requester accept counters for performance monitoring.

## Interface

Parameters:
- `FIXED_PRIORITY`, default 0: 0 = round-robin, 1 = requester 0 always wins ties.

Ports (k = 0, 1):
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_reqk_valid`  in  1  requester k offers an operation.
- `o_reqk_ready`  out  1  requester k's operation is accepted this cycle.
- `i_reqk_insn`  in  16  LC4 instruction word.
- `i_reqk_pc`  in  16  PC operand.
- `i_reqk_r1data`  in  16  rs operand.
- `i_reqk_r2data`  in  16  rt operand.
- `o_rspk_valid`  out  1  result for requester k is available.
- `i_rspk_ready`  in  1  requester k consumes its result.
- `o_rspk_result`  out  16  ALU result for requester k.
- `o_acc_cnt0`, `o_acc_cnt1`  out  16  accepted-operation counters.
- `o_busy`  out  1  op register or either response buffer occupied.

## Operation

- Acceptance: a request is accepted when `i_reqk_valid && o_reqk_ready` at a rising edge.
- Eligibility: requester k is eligible when both of these hold:
  - its response buffer is empty, or is being popped this cycle (`o_rspk_valid && i_rspk_ready`);
  - the op register does not hold an op tagged k.
- Arbitration (combinational):
  - `o_reqk_ready = eligible_k && !(other valid && other eligible && other has priority)`.
  - `o_reqk_ready` does not depend on `i_reqk_valid`.
- Priority:
  - Round-robin: the requester not in `last_grant` has priority. `last_grant` updates only on an accept. Its reset value is 1, so requester 0 wins the first tie.
  - Fixed priority: requester 0 always has priority.
- At most one accept per cycle.
- Op register stage 1: on accept, latch insn, pc, r1data, r2data and tag = k, and set `op_valid`. When no accept occurs, clear `op_valid`.
- ALU/response stage 2: the `lc4_alu` input is driven from the op register. When `op_valid`, write the ALU output into response buffer [tag] and set `rsp_valid[tag]`. A simultaneous pop of that same buffer is legal: the write wins and `rsp_valid` stays 1.
- Response buffer clear: it clears on a pop with no simultaneous write.
- Counters: `o_acc_cntk` increments on each accept by k and wraps 0xFFFF -> 0x0000.
- `o_busy = op_valid | rsp_valid[0] | rsp_valid[1]`.
- Results are bit-exact ALU outputs. There are no width changes.
- The block forwards all opcodes unmodified, including ones the ALU maps to 0x0000.

## Timing

- Latency: accept at edge N -> `o_rspk_valid` = 1 and result stable after edge N+1, i.e. 2 cycles.
- Throughput:
  - per requester, one accept every 2 cycles when its consumer pops immediately;
  - aggregate, one accept per cycle when both requesters alternate.
- A result is held stable while `o_rspk_valid && !i_rspk_ready`. That requester then remains ineligible; the other requester is unaffected.
- Reset (`rst_n` low, asynchronous, including mid-operation):
  - in-flight op and both buffers are discarded;
  - `o_reqk_ready` = 0 while asserted;
  - `o_rspk_valid` = 0, `o_rspk_result` = 0x0000;
  - counters = 0, `o_busy` = 0, `last_grant` = 1.
- First accept possible at the first edge after `rst_n` deasserts.
- Ready outputs are combinational from state and the other requester's valid. There are no combinational paths from `i_rspk_ready` to `o_rspk_*`.

## Test plan

- Single ADD, round-robin:
  - stimulus: req0 insn 0x1042, r1 = 5, r2 = 7;
  - required: accepted at edge 0, `o_rsp0_valid` after edge 1 with result 0x000C, `o_acc_cnt0` = 1.
- Tie and alternation:
  - stimulus: both requesters continuously valid; req0 CONST 0x91FF; req1 TRAP 0xF025; both consumers always ready;
  - required: grants 0,1,0,1…; rsp0 = 0xFFFF, rsp1 = 0x8025; one accept per cycle aggregate.
- Backpressure:
  - stimulus: `i_rsp0_ready` = 0 for 5 cycles after a result;
  - required: `o_rsp0_result` holds; `o_req0_ready` = 0 throughout; req1 is still served every 2 cycles; req0 resumes on the pop cycle.
- Fixed priority:
  - stimulus: `FIXED_PRIORITY` = 1, both requesters valid, consumers ready;
  - required: req0 is granted whenever eligible; req1 is granted only in the cycles req0 is ineligible.
- Reset mid-flight:
  - stimulus: assert `rst_n` low one cycle after an accept;
  - required: `o_rsp0_valid` never rises, counters read 0, `o_busy` = 0 immediately (asynchronous).
- Counter wrap:
  - stimulus: force 65536 accepts on req1;
  - required: `o_acc_cnt1` reads 0x0000 after the last accept.
